// File: rtl/debug_bridge_pkg.sv
// Shared debug-bridge definitions: FSM encodings, starvation defaults and counter helper.
package debug_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PEND    = 2'd1,
        ST_ISSUE   = 2'd2,
        ST_WAIT_RD = 2'd3
    } bridge_state_e;

    localparam int unsigned STARVE_LIMIT_DEFAULT = 16;
    localparam int unsigned STARVE_CNT_W         = 8;
    localparam logic [STARVE_CNT_W-1:0] STARVE_CNT_MAX = '1;

    // Saturating increment for the starvation counter.
    function automatic logic [STARVE_CNT_W-1:0] starve_next(input logic [STARVE_CNT_W-1:0] cnt);
        return (cnt == STARVE_CNT_MAX) ? cnt : cnt + STARVE_CNT_W'(1);
    endfunction

endpackage

// File: rtl/debug_mem_bridge.sv
// Debug memory bridge: shares one single-port SRAM between the core and a debug
// requester. Debug waits for a free slot, a halted core, or starvation timeout,
// then steals exactly one cycle of the memory port.
module debug_mem_bridge
    import debug_bridge_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32
) (
    input  logic          cpu_clk,
    input  logic          sys_rstn,

    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    input  logic          dbg_ce,
    input  logic          dbg_we,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_rdata_ready,
    output logic          dbg_overrun,

    input  logic          cpu_halted,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    input  logic          core_ce,
    input  logic          core_we,
    output logic          core_stall,
    output logic [DW-1:0] core_rdata,
    output logic          core_rdata_valid,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_ce,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    bridge_state_e           state_q;
    bridge_state_e           state_d;

    logic [AW-1:0]           req_addr;
    logic [DW-1:0]           req_wdata;
    logic                    req_we;
    logic [STARVE_CNT_W-1:0] starve_cnt;

    logic                    accept_c;
    logic                    drop_c;
    logic                    limit_hit_c;

    // Request acceptance only in IDLE; a strobe anywhere else is dropped.
    assign accept_c    = dbg_ce && (state_q == ST_IDLE);
    assign drop_c      = dbg_ce && (state_q != ST_IDLE);
    assign limit_hit_c = (starve_cnt == STARVE_CNT_W'(STARVE_LIMIT));

    // Read data goes straight back to the core; validity is tracked separately.
    assign core_rdata = mem_rdata;

    // State register.
    always_ff @(posedge cpu_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus memory-port mux and core stall.
    always_comb begin
        state_d    = state_q;
        mem_addr   = core_addr;
        mem_wdata  = core_wdata;
        mem_ce     = core_ce;
        mem_we     = core_we;
        core_stall = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (dbg_ce) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (!core_ce || cpu_halted || limit_hit_c) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_addr   = req_addr;
                mem_wdata  = req_wdata;
                mem_ce     = 1'b1;
                mem_we     = req_we;
                core_stall = core_ce;
                state_d    = req_we ? ST_IDLE : ST_WAIT_RD;
            end
            ST_WAIT_RD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Latch the debug request on acceptance; dropped strobes leave it untouched.
    always_ff @(posedge cpu_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            req_addr  <= '0;
            req_wdata <= '0;
            req_we    <= 1'b0;
        end else if (accept_c) begin
            req_addr  <= dbg_addr;
            req_wdata <= dbg_wdata;
            req_we    <= dbg_we;
        end
    end

    // Count cycles spent waiting in PEND; cleared whenever PEND is left.
    always_ff @(posedge cpu_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            starve_cnt <= '0;
        end else if ((state_q == ST_PEND) && (state_d == ST_PEND)) begin
            starve_cnt <= starve_next(starve_cnt);
        end else begin
            starve_cnt <= '0;
        end
    end

    // Sticky overrun flag; a new accepted request wins over a drop.
    always_ff @(posedge cpu_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            dbg_overrun <= 1'b0;
        end else if (accept_c) begin
            dbg_overrun <= 1'b0;
        end else if (drop_c) begin
            dbg_overrun <= 1'b1;
        end
    end

    // Capture SRAM read data for debug and flag it one cycle later.
    always_ff @(posedge cpu_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            dbg_rdata       <= '0;
            dbg_rdata_ready <= 1'b0;
        end else begin
            dbg_rdata_ready <= (state_q == ST_WAIT_RD);
            if (state_q == ST_WAIT_RD) begin
                dbg_rdata <= mem_rdata;
            end
        end
    end

    // Core read data is valid the cycle after an unstalled core access.
    always_ff @(posedge cpu_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            core_rdata_valid <= 1'b0;
        end else begin
            core_rdata_valid <= core_ce && !core_stall;
        end
    end

endmodule
